// File: rtl/demux_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | demux_sequencer : en/sel sequencer for a 1-to-4 one-hot demux (scan or    |
// | single-shot), with an en-low gap around every sel change.                 |
// | Optional feature macro: DEMUX_SEQ_SKIP_EN (ch_mask channel skipping).     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module demux_sequencer #(
  parameter int DWELL_W    = 8,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
`ifdef DEMUX_SEQ_SKIP_EN
  input  logic [3:0]         ch_mask,
`endif
  input  logic               req_valid,
  input  logic [1:0]         req_sel,
  output logic               req_ready,
  output logic               en,
  output logic [1:0]         sel,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   scan_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [3:0]         C_GAP_LAST  = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
  localparam logic [DWELL_W-1:0] C_DWELL_ONE = DWELL_W'(1);
  localparam logic [CNT_W-1:0]   C_CNT_ONE   = CNT_W'(1);

  state_t             r_state, w_state;
  logic               r_en, w_en;
  logic [1:0]         r_sel, w_sel;
  logic               r_busy;
  logic               r_done, w_done;
  logic [CNT_W-1:0]   r_scan, w_scan;
  logic               r_stop, w_stop;
  logic               r_halt, w_halt;
  logic               r_single, w_single;
  logic [DWELL_W-1:0] r_cnt, w_cnt;
  logic [3:0]         r_gap, w_gap;
  logic [DWELL_W-1:0] w_dwell_last;
  logic               w_step;
  logic               w_found;
  logic [1:0]         w_nxt;

`ifdef DEMUX_SEQ_SKIP_EN
  // {found, ch}: nearest enabled channel after cur, wrapping round to cur itself
  function automatic logic [2:0] next_ch(input logic [1:0] cur, input logic [3:0] mask);
    logic [2:0] res;
    logic [1:0] c;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      c = cur + 2'(k);
      if (mask[c]) res = {1'b1, c};
    end
    return res;
  endfunction
`endif

  always_comb begin
    w_state      = r_state;
    w_en         = r_en;
    w_sel        = r_sel;
    w_done       = 1'b0;
    w_single     = r_single;
    w_cnt        = r_cnt;
    w_gap        = r_gap;
    w_scan       = r_scan;
    w_halt       = r_halt;
    w_stop       = r_stop | (stop & (r_state != S_IDLE));
    w_step       = 1'b0;
    w_dwell_last = (dwell == '0) ? '0 : dwell - C_DWELL_ONE;
`ifdef DEMUX_SEQ_SKIP_EN
    {w_found, w_nxt} = next_ch(r_sel, ch_mask);
`else
    w_found = 1'b1;
    w_nxt   = r_sel + 2'd1;
`endif

    case (r_state)
      S_IDLE: begin
        w_stop = 1'b0;
        if (start) begin
`ifdef DEMUX_SEQ_SKIP_EN
          {w_found, w_nxt} = next_ch(2'd3, ch_mask);
          if (w_found) begin
            w_state  = S_DRIVE;
            w_en     = 1'b1;
            w_sel    = w_nxt;
            w_cnt    = w_dwell_last;
            w_single = 1'b0;
            w_halt   = 1'b0;
          end
`else
          w_state  = S_DRIVE;
          w_en     = 1'b1;
          w_sel    = 2'd0;
          w_cnt    = w_dwell_last;
          w_single = 1'b0;
          w_halt   = 1'b0;
`endif
        end else if (req_valid) begin
          w_state  = S_DRIVE;
          w_en     = 1'b1;
          w_sel    = req_sel;
          w_cnt    = w_dwell_last;
          w_single = 1'b1;
          w_halt   = 1'b0;
        end
      end
      S_DRIVE: begin
        if (r_cnt == '0) begin
          // stop is only honoured here, at the end of an on-phase
          w_halt = w_stop;
          if ((r_sel == 2'd3) && !r_single) w_scan = r_scan + C_CNT_ONE;
          if (GAP_CYCLES == 0) begin
            w_step = 1'b1;
          end else begin
            w_state = S_GAP;
            w_en    = 1'b0;
            w_gap   = C_GAP_LAST;
          end
        end else begin
          w_cnt = r_cnt - C_DWELL_ONE;
        end
      end
      S_GAP: begin
        if (r_gap == 4'd0) w_step = 1'b1;
        else               w_gap  = r_gap - 4'd1;
      end
      default: w_state = S_IDLE;
    endcase

    if (w_step) begin
      if (r_single || w_halt || !w_found) begin
        w_state = S_IDLE;
        w_en    = 1'b0;
        w_done  = 1'b1;
        w_stop  = 1'b0;
        w_halt  = 1'b0;
      end else begin
        w_state = S_DRIVE;
        w_en    = 1'b1;
        w_sel   = w_nxt;
        w_cnt   = w_dwell_last;
`ifdef DEMUX_SEQ_SKIP_EN
        // wrapping past ch3 without having driven it still counts as a full scan
        if ((w_nxt <= r_sel) && (r_sel != 2'd3)) w_scan = w_scan + C_CNT_ONE;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_en     <= 1'b0;
      r_sel    <= 2'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_scan   <= '0;
      r_stop   <= 1'b0;
      r_halt   <= 1'b0;
      r_single <= 1'b0;
      r_cnt    <= '0;
      r_gap    <= 4'd0;
    end else begin
      r_state  <= w_state;
      r_en     <= w_en;
      r_sel    <= w_sel;
      r_busy   <= (w_state != S_IDLE);
      r_done   <= w_done;
      r_scan   <= w_scan;
      r_stop   <= w_stop;
      r_halt   <= w_halt;
      r_single <= w_single;
      r_cnt    <= w_cnt;
      r_gap    <= w_gap;
    end
  end

  assign req_ready  = (r_state == S_IDLE) & ~start;
  assign en         = r_en;
  assign sel        = r_sel;
  assign busy       = r_busy;
  assign done       = r_done;
  assign scan_count = r_scan;

endmodule
`default_nettype wire

// File: tb/tb_demux_sequencer.sv
`default_nettype none
// Scoreboard bench for demux_sequencer: per-cycle expected {en,sel,busy,done,scan_count}
// vectors are queued with the stimulus and popped against the DUT on each falling edge.
module tb_demux_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start, stop, req_valid;
  logic [1:0] req_sel;
  logic [7:0] dwell;
  logic       req_ready, en, busy, done;
  logic [1:0] sel;
  logic [7:0] scan_count;
  logic [3:0] mask;

  logic       start0, stop0;
  logic [7:0] dwell0;
  logic       req_ready0, en0, busy0, done0;
  logic [1:0] sel0;
  logic [7:0] scan_count0;

  logic [12:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  demux_sequencer #(.DWELL_W(8), .GAP_CYCLES(1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dwell(dwell),
`ifdef DEMUX_SEQ_SKIP_EN
    .ch_mask(mask),
`endif
    .req_valid(req_valid), .req_sel(req_sel), .req_ready(req_ready),
    .en(en), .sel(sel), .busy(busy), .done(done), .scan_count(scan_count)
  );

  demux_sequencer #(.DWELL_W(8), .GAP_CYCLES(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .stop(stop0), .dwell(dwell0),
`ifdef DEMUX_SEQ_SKIP_EN
    .ch_mask(4'hF),
`endif
    .req_valid(1'b0), .req_sel(2'b00), .req_ready(req_ready0),
    .en(en0), .sel(sel0), .busy(busy0), .done(done0), .scan_count(scan_count0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] pk(input logic e, input logic [1:0] s, input logic b,
                                     input logic d, input int sc);
    return {e, s, b, d, 8'(sc)};
  endfunction

  task automatic test_reset();
    logic [13:0] got;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    got = {1'b0, en, sel, busy, done, scan_count};
    n_checks++;
    if (got !== 14'd0) begin
      n_fail++; $display("FAIL reset_hold: got %b expected %b", got, 14'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    got = {en, sel, busy, done, scan_count, req_ready};
    n_checks++;
    if (got !== 14'd1) begin
      n_fail++; $display("FAIL reset_release: got %b expected %b", got, 14'd1);
    end
    got = {en0, sel0, busy0, done0, scan_count0, req_ready0};
    n_checks++;
    if (got !== 14'd1) begin
      n_fail++; $display("FAIL reset_release_gap0: got %b expected %b", got, 14'd1);
    end
  endtask

  task automatic test_single();
    logic [12:0] e, got;
    // dwell=3 to ch2; dwell changed after entry must not stretch the pulse
    @(negedge clk);
    dwell = 8'd3; req_sel = 2'd2; req_valid = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_ready_idle: got %b expected 1", req_ready);
    end
    repeat (3) exp_q.push_back(pk(1'b1, 2'd2, 1'b1, 1'b0, 0));
    exp_q.push_back(pk(1'b0, 2'd2, 1'b1, 1'b0, 0));
    exp_q.push_back(pk(1'b0, 2'd2, 1'b0, 1'b1, 0));
    exp_q.push_back(pk(1'b0, 2'd2, 1'b0, 1'b0, 0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      if (i == 0) begin
        req_valid = 1'b0; dwell = 8'd7;
        n_checks++;
        if (req_ready !== 1'b0) begin
          n_fail++; $display("FAIL single_ready_busy: got %b expected 0", req_ready);
        end
      end
      e = exp_q.pop_front(); got = {en, sel, busy, done, scan_count};
      n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL single_d3 cycle %0d: got %b expected %b", i, got, e);
      end
    end
    // dwell=0 behaves as dwell=1
    dwell = 8'd0; req_sel = 2'd1; req_valid = 1'b1;
    exp_q.push_back(pk(1'b1, 2'd1, 1'b1, 1'b0, 0));
    exp_q.push_back(pk(1'b0, 2'd1, 1'b1, 1'b0, 0));
    exp_q.push_back(pk(1'b0, 2'd1, 1'b0, 1'b1, 0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      if (i == 0) req_valid = 1'b0;
      e = exp_q.pop_front(); got = {en, sel, busy, done, scan_count};
      n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL single_d0 cycle %0d: got %b expected %b", i, got, e);
      end
    end
  endtask

  task automatic test_scan();
    logic [12:0] e, got;
    // stop raised while idle must be ignored
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0; start = 1'b1; dwell = 8'd2;
    for (int i = 0; i < 15; i++)
      exp_q.push_back(pk((i % 3) < 2, 2'((i / 3) % 4), 1'b1, 1'b0, (i >= 11) ? 1 : 0));
    exp_q.push_back(pk(1'b0, 2'd0, 1'b0, 1'b1, 1));
    exp_q.push_back(pk(1'b0, 2'd0, 1'b0, 1'b0, 1));
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      if (i == 0)  start = 1'b0;
      if (i == 12) stop  = 1'b1;
      if (i == 13) stop  = 1'b0;
      e = exp_q.pop_front(); got = {en, sel, busy, done, scan_count};
      n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL scan cycle %0d: got %b expected %b", i, got, e);
      end
    end
  endtask

  task automatic test_priority_reset();
    logic [12:0] e, got;
    @(negedge clk);
    start = 1'b1; req_valid = 1'b1; req_sel = 2'd3; dwell = 8'd4;
    #1;
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL prio_ready: got %b expected 0", req_ready);
    end
    repeat (2) exp_q.push_back(pk(1'b1, 2'd0, 1'b1, 1'b0, 1));
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      if (i == 0) begin start = 1'b0; req_valid = 1'b0; end
      e = exp_q.pop_front(); got = {en, sel, busy, done, scan_count};
      n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL prio cycle %0d: got %b expected %b", i, got, e);
      end
    end
    // asynchronous reset in the middle of DRIVE, no clock edge in between
    rst_n = 1'b0;
    #1;
    got = {en, sel, busy, done, scan_count};
    n_checks++;
    if (got !== 13'd0) begin
      n_fail++; $display("FAIL async_reset: got %b expected %b", got, 13'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [12:0] e, got;
    @(negedge clk);
    start0 = 1'b1; dwell0 = 8'd0;
    for (int i = 0; i < 7; i++)
      exp_q.push_back(pk(1'b1, 2'(i % 4), 1'b1, 1'b0, (i >= 4) ? 1 : 0));
    exp_q.push_back(pk(1'b0, 2'd2, 1'b0, 1'b1, 1));
    exp_q.push_back(pk(1'b0, 2'd2, 1'b0, 1'b0, 1));
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      if (i == 0) start0 = 1'b0;
      if (i == 6) stop0  = 1'b1;
      if (i == 7) stop0  = 1'b0;
      e = exp_q.pop_front(); got = {en0, sel0, busy0, done0, scan_count0};
      n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL back_to_back cycle %0d: got %b expected %b", i, got, e);
      end
    end
  endtask

`ifdef DEMUX_SEQ_SKIP_EN
  task automatic test_skip();
    logic [12:0] e, got;
    @(negedge clk);
    mask = 4'b0000; start = 1'b1; dwell = 8'd1;
    repeat (2) begin
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if ({busy, done} !== 2'b00) begin
        n_fail++; $display("FAIL skip_mask0: got %b expected 00", {busy, done});
      end
    end
    mask = 4'b0101; start = 1'b1;
    exp_q.push_back(pk(1'b1, 2'd0, 1'b1, 1'b0, 0));
    exp_q.push_back(pk(1'b0, 2'd0, 1'b1, 1'b0, 0));
    exp_q.push_back(pk(1'b1, 2'd2, 1'b1, 1'b0, 0));
    exp_q.push_back(pk(1'b0, 2'd2, 1'b1, 1'b0, 0));
    exp_q.push_back(pk(1'b1, 2'd0, 1'b1, 1'b0, 1));
    exp_q.push_back(pk(1'b0, 2'd0, 1'b1, 1'b0, 1));
    exp_q.push_back(pk(1'b0, 2'd0, 1'b0, 1'b1, 1));
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      if (i == 4) stop  = 1'b1;
      if (i == 5) stop  = 1'b0;
      e = exp_q.pop_front(); got = {en, sel, busy, done, scan_count};
      n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL skip cycle %0d: got %b expected %b", i, got, e);
      end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; req_valid = 1'b0; req_sel = 2'd0;
    dwell = 8'd0; mask = 4'hF; start0 = 1'b0; stop0 = 1'b0; dwell0 = 8'd0;
    #2;
    test_reset();
    test_single();
    test_scan();
    test_priority_reset();
    test_back_to_back();
`ifdef DEMUX_SEQ_SKIP_EN
    test_skip();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
